// File: rtl/ula_resources.sv
// Shared types and defaults for the ula datapath and its downstream result collector.
package ula_resources;

    localparam int ULA_DATA_WIDTH  = 8;
    localparam int COLLECTOR_DEPTH = 8;

    typedef struct packed {
        logic                      carryout;
        logic [ULA_DATA_WIDTH-1:0] result;
    } ula_result_t;

endpackage : ula_resources

// File: rtl/ula_sync_fifo.sv
// Generic first-word-fall-through FIFO with registered count/full/empty and synchronous clear.
module ula_sync_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    next_count;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        next_count = count;
        if (do_push && !do_pop) begin
            next_count = count + CW'(1);
        end else if (do_pop && !do_push) begin
            next_count = count - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= next_count;
            full  <= (next_count == CW'(DEPTH));
            empty <= (next_count == '0);
        end
    end

    // NOTE: storage is deliberately not reset; valid/empty gating hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];

endmodule : ula_sync_fifo

// File: rtl/ula_result_collector.sv
// Buffers ula results in a FWFT FIFO, hands them out over valid/ready and keeps loss/carry statistics.
module ula_result_collector
    import ula_resources::*;
#(
    parameter  int DATA_WIDTH = ULA_DATA_WIDTH,
    parameter  int DEPTH      = COLLECTOR_DEPTH,
    parameter  int CNT_WIDTH  = 16,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_data_valid,
    input  logic [DATA_WIDTH-1:0] i_data_result,
    input  logic                  i_data_carryout,
    input  logic                  i_clear,
    input  logic                  i_data_ready,
    output logic                  o_data_valid,
    output logic [DATA_WIDTH-1:0] o_data_result,
    output logic                  o_data_carryout,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CW-1:0]         o_count,
    output logic [CNT_WIDTH-1:0]  o_drop_count,
    output logic [CNT_WIDTH-1:0]  o_carry_count
);

    logic                flush;
    logic                pop;
    logic                push;
    logic                drop;
    logic [DATA_WIDTH:0] head;

    assign flush = rst || i_clear;
    assign pop   = o_data_valid && i_data_ready;
    assign push  = i_data_valid && (!o_full || pop);
    assign drop  = i_data_valid && o_full && !pop;

    ula_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({i_data_carryout, i_data_result}),
        .rdata (head),
        .full  (o_full),
        .empty (o_empty),
        .count (o_count)
    );

    assign o_data_valid    = !o_empty;
    assign o_data_result   = o_empty ? '0 : head[DATA_WIDTH-1:0];
    assign o_data_carryout = o_empty ? 1'b0 : head[DATA_WIDTH];

    // Both statistics hold at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (flush) begin
            o_drop_count  <= '0;
            o_carry_count <= '0;
        end else begin
            if (drop && (o_drop_count != '1)) begin
                o_drop_count <= o_drop_count + CNT_WIDTH'(1);
            end
            if (push && i_data_carryout && (o_carry_count != '1)) begin
                o_carry_count <= o_carry_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule : ula_result_collector
